// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle MIPS-style datapath.
// Supports RTYPE, LW, SW and BEQ. Any other opcode goes through a one-cycle TRAP.
// It also counts retired instructions.
//
// Optional feature: define MEM_WAIT_EN to hold MEM until mem_ready=1.
// When it is undefined, MEM always lasts one cycle and mem_ready is ignored.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   run           allows the next instruction fetch
//   opcode        instruction[31:26] from IR, sampled only in DECODE
//   zero          ALU zero flag, drives pc_we directly in BEQ-EXEC
//   mem_ready     data memory done (MEM_WAIT_EN only)
//   ir_we, pc_we, pc_sel, br_en, mem_r, mem_w, mem_to_br, reg_dest,
//   alu_src, alu_op, illegal
//                 datapath strobes, decoded from state and the latched opcode
//   state         current state code
//   retired       completed-instruction count, wraps
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        br_en,
   output logic        mem_r,
   output logic        mem_w,
   output logic        mem_to_br,
   output logic        reg_dest,
   output logic        alu_src,
   output logic [2:0]  alu_op,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   localparam int unsigned OpW  = 6;
   localparam int unsigned RetW = 32;

   localparam logic [OpW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OpW-1:0] OP_LW    = 6'b100011;
   localparam logic [OpW-1:0] OP_SW    = 6'b101011;
   localparam logic [OpW-1:0] OP_BEQ   = 6'b000100;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } stateT;

   stateT            curState;
   logic [OpW-1:0]   opQ;
   logic             memDone;
   logic             opcodeLegal;

`ifdef MEM_WAIT_EN
   assign memDone = mem_ready;
`else
   // mem_ready has no function in this build.
   logic unusedMemReady;
   assign unusedMemReady = mem_ready;
   assign memDone        = 1'b1;
`endif

   assign opcodeLegal = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                        (opcode == OP_SW)    || (opcode == OP_BEQ);

   assign state = curState;

   // State sequencing, opcode latch and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= FETCH;
         opQ      <= '0;
         retired  <= '0;
      end else begin
         case (curState)
            FETCH: begin
               if (run) curState <= DECODE;
            end
            DECODE: begin
               opQ      <= opcode;
               curState <= opcodeLegal ? EXEC : TRAP;
            end
            EXEC: begin
               case (opQ)
                  OP_RTYPE:     curState <= WB;
                  OP_LW, OP_SW: curState <= MEM;
                  OP_BEQ: begin
                     curState <= FETCH;
                     retired  <= retired + RetW'(1);
                  end
                  default:      curState <= FETCH;
               endcase
            end
            MEM: begin
               if (memDone) begin
                  if (opQ == OP_LW) begin
                     curState <= WB;
                  end else begin
                     curState <= FETCH;
                     if (opQ == OP_SW) retired <= retired + RetW'(1);
                  end
               end
            end
            WB: begin
               curState <= FETCH;
               retired  <= retired + RetW'(1);
            end
            TRAP:    curState <= FETCH;
            default: curState <= FETCH;
         endcase
      end
   end

   // Strobe decode. rst gates everything so FETCH cannot fire while reset is held.
   always_comb begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      br_en     = 1'b0;
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      mem_to_br = 1'b0;
      reg_dest  = 1'b0;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      illegal   = 1'b0;
      if (!rst) begin
         case (curState)
            FETCH: begin
               ir_we = run;
               pc_we = run;
            end
            EXEC: begin
               case (opQ)
                  OP_RTYPE: alu_op = ALU_FUNCT;
                  OP_LW, OP_SW: begin
                     alu_op  = ALU_ADD;
                     alu_src = 1'b1;
                  end
                  OP_BEQ: begin
                     alu_op = ALU_SUB;
                     pc_sel = 1'b1;
                     pc_we  = zero;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               mem_r = (opQ == OP_LW);
               mem_w = (opQ == OP_SW);
            end
            WB: begin
               br_en     = 1'b1;
               reg_dest  = (opQ == OP_RTYPE);
               mem_to_br = (opQ == OP_LW);
            end
            TRAP:    illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl.
// It applies a reset and a vector table, then fixed LW/SW and reset sequences.
// It ends with random instruction streams checked against an instruction-level model.
// The MEM wait checks follow MEM_WAIT_EN, so the same file covers both builds.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                          S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

   // Strobe bits: {ir_we,pc_we,pc_sel,br_en,mem_r,mem_w,mem_to_br,reg_dest,alu_src,alu_op[2:0],illegal}
   localparam logic [12:0] IRWE = 13'h1000, PCWE = 13'h0800, PCSEL = 13'h0400,
                           BREN = 13'h0200, MEMR = 13'h0100, MEMW = 13'h0080,
                           M2B  = 13'h0040, RDST = 13'h0020, ASRC = 13'h0010,
                           ALU_SUB = 13'h0002, ALU_FN = 13'h0004, ILL = 13'h0001,
                           NONE = 13'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [5:0]  opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        ir_we, pc_we, pc_sel, br_en, mem_r, mem_w, mem_to_br;
   logic        reg_dest, alu_src, illegal;
   logic [2:0]  alu_op;
   logic [2:0]  state;
   logic [31:0] retired;

   int          nTests = 0;
   int          nFail  = 0;
   logic [31:0] modelRet = '0;

   typedef struct {
      logic        rst;
      logic        run;
      logic [5:0]  opcode;
      logic        zero;
      logic        memReady;
      logic [2:0]  expState;
      logic [12:0] expCtl;
      logic [31:0] expRet;
   } vecT;

   vecT vecs[16];

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .br_en(br_en), .mem_r(mem_r), .mem_w(mem_w), .mem_to_br(mem_to_br),
      .reg_dest(reg_dest), .alu_src(alu_src), .alu_op(alu_op),
      .illegal(illegal), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] actCtl();
      return {ir_we, pc_we, pc_sel, br_en, mem_r, mem_w, mem_to_br,
              reg_dest, alu_src, alu_op, illegal};
   endfunction

   task automatic check(input logic [2:0] eState, input logic [12:0] eCtl,
                        input logic [31:0] eRet, input string name);
      nTests++;
      if (state !== eState || actCtl() !== eCtl || retired !== eRet) begin
         nFail++;
         $display("FAIL %s: got state=%0d ctl=%h retired=%0d, want state=%0d ctl=%h retired=%0d",
                  name, state, actCtl(), retired, eState, eCtl, eRet);
      end
   endtask

   // One clock cycle: drive at the falling edge, check outputs 1ns later.
   task automatic cyc(input logic r, input logic rn, input logic [5:0] op,
                      input logic z, input logic mr, input logic [2:0] eState,
                      input logic [12:0] eCtl, input logic [31:0] eRet,
                      input string name);
      @(negedge clk);
      rst = r; run = rn; opcode = op; zero = z; mem_ready = mr;
      #1;
      check(eState, eCtl, eRet, name);
   endtask

   // Instruction-level reference: the cycle-by-cycle expectations for one instruction.
   // Inputs that should not matter in a cycle are randomised.
   task automatic runInstr(input logic [5:0] op, input logic z, input int waits);
      logic [12:0] memStrobe;
      cyc(1'b0, 1'b1, 6'($urandom), 1'($urandom), 1'($urandom),
          S_FETCH, IRWE | PCWE, modelRet, "fetch");
      cyc(1'b0, 1'($urandom), op, 1'($urandom), 1'($urandom),
          S_DECODE, NONE, modelRet, "decode");
      if (op == OP_RTYPE) begin
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
             S_EXEC, ALU_FN, modelRet, "rtype_exec");
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
             S_WB, BREN | RDST, modelRet, "rtype_wb");
         modelRet = modelRet + 32'd1;
      end else if (op == OP_LW || op == OP_SW) begin
         memStrobe = (op == OP_LW) ? MEMR : MEMW;
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
             S_EXEC, ASRC, modelRet, "ldst_exec");
`ifdef MEM_WAIT_EN
         for (int i = 0; i < waits; i++)
            cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                S_MEM, memStrobe, modelRet, "mem_wait");
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1,
             S_MEM, memStrobe, modelRet, "mem_last");
`else
         // A pending wait still leaves MEM after one cycle.
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom),
             (waits > 0) ? 1'b0 : 1'($urandom),
             S_MEM, memStrobe, modelRet, "mem");
`endif
         if (op == OP_LW)
            cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                S_WB, BREN | M2B, modelRet, "lw_wb");
         modelRet = modelRet + 32'd1;
      end else if (op == OP_BEQ) begin
         cyc(1'b0, 1'($urandom), 6'($urandom), z, 1'($urandom),
             S_EXEC, PCSEL | ALU_SUB | (z ? PCWE : NONE), modelRet, "beq_exec");
         modelRet = modelRet + 32'd1;
      end else begin
         cyc(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
             S_TRAP, ILL, modelRet, "trap");
      end
   endtask

   initial begin
      // Reset, RTYPE, BEQ taken and not taken, illegal opcode.
      vecs[0]  = '{1'b1, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  NONE,        32'd0};
      vecs[1]  = '{1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  IRWE | PCWE, 32'd0};
      vecs[2]  = '{1'b0, 1'b0, OP_RTYPE, 1'b0, 1'b0, S_DECODE, NONE,        32'd0};
      vecs[3]  = '{1'b0, 1'b1, OP_BAD,   1'b1, 1'b1, S_EXEC,   ALU_FN,      32'd0};
      vecs[4]  = '{1'b0, 1'b0, OP_LW,    1'b0, 1'b0, S_WB,     BREN | RDST, 32'd0};
      vecs[5]  = '{1'b0, 1'b0, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  NONE,        32'd1};
      vecs[6]  = '{1'b0, 1'b1, OP_SW,    1'b0, 1'b0, S_FETCH,  IRWE | PCWE, 32'd1};
      vecs[7]  = '{1'b0, 1'b0, OP_BEQ,   1'b0, 1'b0, S_DECODE, NONE,        32'd1};
      vecs[8]  = '{1'b0, 1'b0, OP_RTYPE, 1'b1, 1'b0, S_EXEC,   PCWE | PCSEL | ALU_SUB, 32'd1};
      vecs[9]  = '{1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  IRWE | PCWE, 32'd2};
      vecs[10] = '{1'b0, 1'b0, OP_BEQ,   1'b1, 1'b0, S_DECODE, NONE,        32'd2};
      vecs[11] = '{1'b0, 1'b0, OP_BEQ,   1'b0, 1'b0, S_EXEC,   PCSEL | ALU_SUB, 32'd2};
      vecs[12] = '{1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  IRWE | PCWE, 32'd3};
      vecs[13] = '{1'b0, 1'b0, OP_BAD,   1'b0, 1'b0, S_DECODE, NONE,        32'd3};
      vecs[14] = '{1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_TRAP,   ILL,         32'd3};
      vecs[15] = '{1'b0, 1'b0, OP_RTYPE, 1'b0, 1'b0, S_FETCH,  NONE,        32'd3};

      for (int i = 0; i < 16; i++)
         cyc(vecs[i].rst, vecs[i].run, vecs[i].opcode, vecs[i].zero, vecs[i].memReady,
             vecs[i].expState, vecs[i].expCtl, vecs[i].expRet, $sformatf("vec%0d", i));
      modelRet = 32'd3;

      // LW then SW, then LW with mem_ready held low for three MEM cycles.
      runInstr(OP_LW, 1'b0, 0);
      runInstr(OP_SW, 1'b0, 0);
      runInstr(OP_LW, 1'b0, 3);

      // Reset arrives in the middle of a LW's EXEC cycle.
      cyc(1'b0, 1'b1, OP_RTYPE, 1'b0, 1'b0, S_FETCH, IRWE | PCWE, modelRet, "rst_fetch");
      cyc(1'b0, 1'b0, OP_LW,    1'b0, 1'b0, S_DECODE, NONE, modelRet, "rst_decode");
      cyc(1'b0, 1'b0, OP_LW,    1'b0, 1'b1, S_EXEC, ASRC, modelRet, "rst_exec");
      #1 rst = 1'b1;
      #1 check(S_FETCH, NONE, 32'd0, "rst_async");
      modelRet = '0;
      cyc(1'b1, 1'b1, OP_LW, 1'b1, 1'b1, S_FETCH, NONE, modelRet, "rst_hold_run");
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, 6'($urandom), 1'($urandom), 1'($urandom),
             S_FETCH, NONE, modelRet, "rst_idle");

      // Random instruction stream with idle gaps.
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op;
         int gaps;
         gaps = int'($urandom_range(0, 2));
         for (int g = 0; g < gaps; g++)
            cyc(1'b0, 1'b0, 6'($urandom), 1'($urandom), 1'($urandom),
                S_FETCH, NONE, modelRet, "idle");
         case ($urandom_range(0, 4))
            0: op = OP_RTYPE;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            default: op = 6'($urandom);
         endcase
         runInstr(op, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst, where rst=1 forces reset immediately regardless of clk.
REQ-002 The block SHALL have these ports:
  clk  in  1  system clock
  rst  in  1  async active-high reset
  run  in  1  1 = allow next instruction fetch
  opcode  in  6  instruction[31:26] from IR
  zero  in  1  ALU zero flag
  mem_ready  in  1  data memory done; used only with MEM_WAIT_EN
  ir_we  out  1  IR load strobe
  pc_we  out  1  PC write enable
  pc_sel  out  1  0 = PC+4, 1 = branch target
  br_en  out  1  register bank write enable
  mem_r  out  1  data memory read
  mem_w  out  1  data memory write
  mem_to_br  out  1  1 = memory data to bank, 0 = ALU result
  reg_dest  out  1  1 = rd [15:11], 0 = rt [20:16]
  alu_src  out  1  1 = immediate, 0 = register
  alu_op  out  3  to AluCtrl: 000 add, 001 sub, 010 use funct
  illegal  out  1  one-cycle pulse on unsupported opcode
  state  out  3  current state code
  retired  out  32  completed-instruction count

Function
REQ-003 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-004 Supported opcodes SHALL be RTYPE=000000, LW=100011, SW=101011, and BEQ=000100; every other opcode is illegal.
REQ-005 In FETCH with run=1, the block SHALL assert ir_we=1, pc_we=1, and pc_sel=0, then go to DECODE; with run=0 it SHALL stay in FETCH with all strobes at 0.
REQ-006 In DECODE, the block SHALL latch opcode into an internal op_q, go to EXEC for a supported opcode, and go to TRAP otherwise; all strobes are 0.
REQ-007 In EXEC for RTYPE, outputs SHALL be alu_op=010 and alu_src=0, and the next state SHALL be WB.
REQ-008 In EXEC for LW or SW, outputs SHALL be alu_op=000 and alu_src=1, and the next state SHALL be MEM.
REQ-009 In EXEC for BEQ, outputs SHALL be alu_op=001, alu_src=0, pc_sel=1, and pc_we=zero (combinational), and the next state SHALL be FETCH.
REQ-010 In MEM, LW SHALL assert mem_r=1 and go to WB; SW SHALL assert mem_w=1 and go to FETCH.
REQ-011 In WB, the block SHALL assert br_en=1; RTYPE SHALL use reg_dest=1 and mem_to_br=0, LW SHALL use reg_dest=0 and mem_to_br=1; the next state SHALL be FETCH.
REQ-012 In TRAP, the block SHALL assert illegal=1 for exactly one cycle, go to FETCH, and leave retired unchanged.
REQ-013 Outputs SHALL be decoded combinationally from state and op_q (zero excepted); every output not named for a state SHALL be 0 in that state.
REQ-014 retired SHALL increment by 1 on each edge leaving BEQ-EXEC, SW-MEM, or WB, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 Latency SHALL be RTYPE 4 cycles, LW 5, SW 4, BEQ 3, and illegal 3, with no wait states.
REQ-016 Changes on opcode outside DECODE SHALL have no effect.

Reset
REQ-017 While rst=1, the block SHALL hold state=FETCH, op_q=000000, and retired=0.
REQ-018 While rst=1, all strobes SHALL be 0, including ir_we and pc_we, whatever the value of run.
REQ-019 If rst is asserted mid-instruction, the block SHALL abandon that instruction, make no further strobe, and not count it.

Configuration
REQ-020 With MEM_WAIT_EN defined, the block SHALL stay in MEM, holding mem_r or mem_w asserted, until mem_ready=1; it leaves MEM on the edge where mem_ready=1.
REQ-021 With MEM_WAIT_EN undefined, mem_ready SHALL be ignored and MEM SHALL last exactly one cycle.

Verification
REQ-022 The bench SHALL cover these scenarios:
  - Reset then run=1 with RTYPE: states 0,1,2,4,0; br_en=1 and reg_dest=1 only in WB; retired=1.
  - LW then SW, MEM_WAIT_EN undefined: LW takes 5 cycles with mem_r in MEM; SW takes 4 cycles with mem_w; retired=2.
  - BEQ with zero=1, then with zero=0: first gives pc_we=1 and pc_sel=1 in EXEC; second gives pc_we=0; both take 3 cycles.
  - Opcode 111111: DECODE then TRAP; illegal pulses for 1 cycle; retired unchanged.
  - MEM_WAIT_EN defined, LW with mem_ready low for 3 cycles: stays in MEM 4 cycles with mem_r held, then WB.
  - rst pulsed in EXEC of LW: state=0 immediately and retired=0; with run=0 after release, the block stays in FETCH with no strobes.
